decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage; consumes IF packet {pc[63:32], inst[31:0]} from the fetch stage and produces a registered ID packet.
//  Cracks opcode/funct fields, generates the sign-extended immediate and register addresses, and classifies the op.
//  Two-entry elastic buffer (output reg + skid reg) decouples the downstream stall from the fetch stall (o_stall).
// PARAMETERS
//  ADDR_W    32  PC width
//  INST_W    32  instruction width; IF packet width = ADDR_W+INST_W, PC in upper bits
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  i_if_pkt_vld   in   1       IF packet valid
//  i_if_pkt_data  in   64      {pc, inst}
//  o_stall        out  1       to fetch: do not present a new packet
//  i_stall        in   1       from execute: hold ID packet
//  i_flush        in   1       discard all held and incoming packets
//  o_id_vld       out  1       ID packet valid
//  o_pc           out  32      PC of decoded inst
//  o_rs1/o_rs2    out  5 each  source register addresses (0 if unused)
//  o_rd           out  5       destination register
//  o_rd_we        out  1       writes rd (forced 0 when rd==0)
//  o_imm          out  32      sign-extended immediate (I/S/B/U/J)
//  o_funct3       out  3       inst[14:12]
//  o_funct7b5     out  1       inst[30]
//  o_op_class     out  4       0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OPIMM,8 OP,9 FENCE,10 SYSTEM,15 ILLEGAL
//  o_illegal      out  1       illegal instruction flag
// BEHAVIOUR
//  - Reset: all outputs 0, o_id_vld=0, o_stall=0, skid empty.
//  - Accept: i_if_pkt_vld && !o_stall. Latency 1 cycle accept -> o_id_vld.
//  - Output reg loads when empty or (!i_stall): from skid if skid full, else from input.
//  - Output reg full && i_stall && accept: packet decoded into skid reg; o_stall=skid_full (registered).
//  - Skid drains to output the first cycle i_stall=0; o_stall drops the same edge; no packet lost/duplicated.
//  - Order strictly preserved; at most 2 packets held.
//  - i_flush: next edge output+skid cleared, o_id_vld=0, o_stall=0; input that cycle dropped; flush overrides i_stall.
//  - Decode is combinational on the input path; both regs store decoded fields.
//  - Imm: I=inst[31:20], S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, U={[31:12],12'b0},
//    J={[31],[19:12],[20],[30:21],0}; all sign-extended from inst[31].
//  - rs2=0 for I/U/J types; rs1=0 for U/J types; rd_we=0 for BRANCH/STORE/FENCE.
//  - Reset mid-stream: everything cleared asynchronously; no packet survives.
// CONFIGURATION
//  DECODE_ILLEGAL_CHECK_EN defined: unknown opcode, inst[1:0]!=2'b11, bad funct7 on OP/shift-imm
//    -> o_op_class=15, o_illegal=1, o_rd_we=0.
//  Not defined: o_illegal tied 0; unknown opcodes decode as OPIMM with rd_we=0 (NOP); funct7 unchecked.
// STRUCTURE
//  Shared package/include: OP_CLASS_* constants, RV32I opcode constants, ID packet field widths.
//  Sub-module: imm_gen (inst -> 32-bit imm, pure combinational); remainder in decode_stage.
// TESTING
//  1) Stream ADDI x1,x0,5 (0x00500093) pc=0x0 -> next cycle o_id_vld=1, rd=1, rs1=0, imm=5, class=7, rd_we=1.
//  2) BEQ 0xFE000EE3 -> imm=0xFFFFFFFC, class=4, rd_we=0; JAL 0x0080006F -> imm=8, class=2.
//  3) i_stall=1 for 3 cycles, back-to-back packets pc=0x0,0x4,0x8 -> o_stall=1 after 2nd accept;
//     release -> outputs 0x0,0x4,0x8 in order.
//  4) i_flush with both regs full -> next cycle o_id_vld=0, o_stall=0; next packet pc=0x100 decodes normally.
//  5) inst=0xFFFFFFFF: with DECODE_ILLEGAL_CHECK_EN -> class=15, illegal=1; without -> illegal=0, rd_we=0.
//  6) Assert rst_n low mid-stall -> o_id_vld=0, o_stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: op classes, RV32I opcodes, ID packet layout.
// Imported by decode_stage and its immediate generator.
package decode_stage_pkg;

    localparam int REG_W   = 5;
    localparam int XLEN    = 32;
    localparam int CLASS_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [CLASS_W-1:0] OP_CLASS_LUI     = 4'd0;
    localparam logic [CLASS_W-1:0] OP_CLASS_AUIPC   = 4'd1;
    localparam logic [CLASS_W-1:0] OP_CLASS_JAL     = 4'd2;
    localparam logic [CLASS_W-1:0] OP_CLASS_JALR    = 4'd3;
    localparam logic [CLASS_W-1:0] OP_CLASS_BRANCH  = 4'd4;
    localparam logic [CLASS_W-1:0] OP_CLASS_LOAD    = 4'd5;
    localparam logic [CLASS_W-1:0] OP_CLASS_STORE   = 4'd6;
    localparam logic [CLASS_W-1:0] OP_CLASS_OPIMM   = 4'd7;
    localparam logic [CLASS_W-1:0] OP_CLASS_OP      = 4'd8;
    localparam logic [CLASS_W-1:0] OP_CLASS_FENCE   = 4'd9;
    localparam logic [CLASS_W-1:0] OP_CLASS_SYSTEM  = 4'd10;
    localparam logic [CLASS_W-1:0] OP_CLASS_ILLEGAL = 4'd15;

    // Decoded fields held in both the output and skid registers
    typedef struct packed {
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               rd_we;
        logic [XLEN-1:0]    imm;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic [CLASS_W-1:0] op_class;
        logic               illegal;
    } id_pkt_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J format from the opcode.
// Pure combinational; unknown opcodes produce zero.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
);

    // Format selection and sign extension from inst[31]
    always_comb begin
        imm_o = '0;
        unique case (inst_i[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM,
            OPC_FENCE, OPC_SYSTEM:
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                imm_o = {{20{inst_i[31]}}, inst_i[31:25],
                         inst_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {inst_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a two-entry elastic buffer (output + skid).
// Option: DECODE_ILLEGAL_CHECK_EN enables illegal-instruction detection.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_if_pkt_vld,
    input  logic [ADDR_W+INST_W-1:0] i_if_pkt_data,
    output logic                     o_stall,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_id_vld,
    output logic [ADDR_W-1:0]        o_pc,
    output logic [4:0]               o_rs1,
    output logic [4:0]               o_rs2,
    output logic [4:0]               o_rd,
    output logic                     o_rd_we,
    output logic [31:0]              o_imm,
    output logic [2:0]               o_funct3,
    output logic                     o_funct7b5,
    output logic [3:0]               o_op_class,
    output logic                     o_illegal
);

    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       imm;
    logic [4:0]        rd_f;
    logic              writes;
    logic              use_rs1;
    logic              use_rs2;
    id_pkt_t           dec;

    assign inst = i_if_pkt_data[INST_W-1:0];
    assign pc   = i_if_pkt_data[ADDR_W+INST_W-1:INST_W];

    decode_stage_imm_gen u_imm_gen (
        .inst_i (inst[31:0]),
        .imm_o  (imm)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic [6:0] funct7;
    logic       f7_bad;

    assign funct7 = inst[31:25];

    // Reject funct7 encodings RV32I does not define for OP and shifts
    always_comb begin
        f7_bad = 1'b0;
        if (inst[6:0] == OPC_OP) begin
            f7_bad = !((funct7 == 7'h00) ||
                       ((funct7 == 7'h20) &&
                        ((inst[14:12] == 3'd0) ||
                         (inst[14:12] == 3'd5))));
        end else if (inst[6:0] == OPC_OPIMM) begin
            if (inst[14:12] == 3'd1)
                f7_bad = (funct7 != 7'h00);
            else if (inst[14:12] == 3'd5)
                f7_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
    end
`endif

    // Crack the incoming instruction into ID packet fields
    always_comb begin
        dec          = '0;
        writes       = 1'b0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        dec.funct3   = inst[14:12];
        dec.funct7b5 = inst[30];
        dec.imm      = imm;
        dec.op_class = OP_CLASS_OPIMM;
        unique case (inst[6:0])
            OPC_LUI: begin
                dec.op_class = OP_CLASS_LUI;
                writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_class = OP_CLASS_AUIPC;
                writes = 1'b1;
            end
            OPC_JAL: begin
                dec.op_class = OP_CLASS_JAL;
                writes = 1'b1;
            end
            OPC_JALR: begin
                dec.op_class = OP_CLASS_JALR;
                writes = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op_class = OP_CLASS_BRANCH;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.op_class = OP_CLASS_LOAD;
                writes = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.op_class = OP_CLASS_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec.op_class = OP_CLASS_OPIMM;
                writes = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_OP: begin
                dec.op_class = OP_CLASS_OP;
                writes = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_FENCE: begin
                dec.op_class = OP_CLASS_FENCE;
                use_rs1 = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.op_class = OP_CLASS_SYSTEM;
                writes = 1'b1;
                use_rs1 = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_CHECK_EN
                dec.op_class = OP_CLASS_ILLEGAL;
                dec.illegal  = 1'b1;
`else
                dec.op_class = OP_CLASS_OPIMM;
`endif
            end
        endcase
        rd_f      = writes ? inst[11:7] : 5'd0;
        dec.rd    = rd_f;
        dec.rd_we = writes && (rd_f != 5'd0);
        dec.rs1   = use_rs1 ? inst[19:15] : 5'd0;
        dec.rs2   = use_rs2 ? inst[24:20] : 5'd0;
`ifdef DECODE_ILLEGAL_CHECK_EN
        if ((inst[1:0] != 2'b11) || f7_bad) begin
            dec.op_class = OP_CLASS_ILLEGAL;
            dec.illegal  = 1'b1;
        end
        if (dec.illegal)
            dec.rd_we = 1'b0;
`endif
    end

    logic              out_vld_q, out_vld_d;
    logic              skid_vld_q, skid_vld_d;
    id_pkt_t           out_q, out_d;
    id_pkt_t           skid_q, skid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              accept;
    logic              out_load;

    assign accept   = i_if_pkt_vld && !skid_vld_q;
    assign out_load = !out_vld_q || !i_stall;

    // Elastic buffer steering: skid drains first, flush wins over all
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        out_pc_d   = out_pc_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            out_d      = '0;
            out_pc_d   = '0;
            skid_vld_d = 1'b0;
            skid_d     = '0;
            skid_pc_d  = '0;
        end else if (out_load) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = skid_q;
                out_pc_d   = skid_pc_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_d    = dec;
                    out_pc_d = pc;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_d     = dec;
            skid_pc_d  = pc;
        end
    end

    // Output and skid registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            out_pc_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            out_pc_q   <= out_pc_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    assign o_stall    = skid_vld_q;
    assign o_id_vld   = out_vld_q;
    assign o_pc       = out_pc_q;
    assign o_rs1      = out_q.rs1;
    assign o_rs2      = out_q.rs2;
    assign o_rd       = out_q.rd;
    assign o_rd_we    = out_q.rd_we;
    assign o_imm      = out_q.imm;
    assign o_funct3   = out_q.funct3;
    assign o_funct7b5 = out_q.funct7b5;
    assign o_op_class = out_q.op_class;
    assign o_illegal  = out_q.illegal;

endmodule
